// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
//
// Pipelined immediate-generation stage. Widens an IN_W-bit immediate to OUT_W
// bits (sign / zero / upper / branch-offset) and passes the result through a
// valid/ready stage built from an output register plus one skid register, so
// it sustains one result per cycle without a combinational ready path.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream holds a valid immediate
//   in_ready   stage can accept this cycle (decoded from state only)
//   in_imm     raw immediate, IN_W bits
//   in_mode    00 sign, 01 zero, 10 upper, 11 branch
//   out_valid  out_data holds a valid result (decoded from state only)
//   out_ready  downstream accepts this cycle
//   out_data   extended immediate, OUT_W bits
// -----------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'b00,
        MODE_ZERO   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [OUT_W-1:0] skid_q, skid_d;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic             in_xfer;
    logic             out_xfer;

    // Handshake flags come from the state register alone, so neither
    // out_ready nor in_valid reaches an output combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_data_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Extension is done on the input side so both storage registers only
    // ever hold finished results; in_mode is therefore sampled at acceptance.
    assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned; that is what keeps a latch from being inferred.
        ext = sext;
        case (mode_t'(in_mode))
            MODE_SIGN:   ext = sext;
            MODE_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, in_imm};
            MODE_UPPER:  ext = {in_imm, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: ext = sext << 2;
            default:     ext = sext;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_data_d = ext;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    // Old result leaves and the new one replaces it on the same edge.
                    out_data_d = ext;
                end else if (in_xfer) begin
                    skid_d  = ext;
                    state_d = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    out_data_d = skid_q;
                    state_d    = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_pipe
//
// Self-checking bench. A queue-based model of the stage (occupancy 0..2, FIFO
// order, extension computed with integer arithmetic) is compared against the
// 16/32 instance on every falling edge. Directed sequences pin the extension
// values, backpressure, throughput and reset behaviour with literal
// expectations; an 8/16 instance covers the parameter sweep.
// -----------------------------------------------------------------------------
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    logic        in8_valid = 1'b0;
    logic        in8_ready;
    logic [7:0]  in8_imm = '0;
    logic [1:0]  in8_mode = '0;
    logic        out8_valid;
    logic        out8_ready = 1'b0;
    logic [15:0] out8_data;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in8_valid),
        .in_ready  (in8_ready),
        .in_imm    (in8_imm),
        .in_mode   (in8_mode),
        .out_valid (out8_valid),
        .out_ready (out8_ready),
        .out_data  (out8_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference for the 16 -> 32 extension.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint s;
        s = longint'(imm);
        if (s >= 32768) s = s - 65536;
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return 32'(longint'(imm));
            2'd2:    return 32'(longint'(imm) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    // Model: a FIFO of at most two results; accepts while holding fewer than two.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else if (in_valid && model_q.size() < 2) begin
            if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
            model_q.push_back(ref_ext(in_imm, in_mode));
        end else if (model_q.size() > 0 && out_ready) begin
            void'(model_q.pop_front());
        end
    end

    // Compare process: handshake flags every cycle, data whenever it is valid.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model in_ready", 64'(in_ready), 64'(model_q.size() < 2));
            check("model out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            if (out_valid && model_q.size() > 0)
                check("model out_data", 64'(out_data), 64'(model_q[0]));
        end
    end

    logic [31:0] exp_mode[4]  = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010};
    logic [15:0] exp_mode8[4] = '{16'hFF80, 16'h0080, 16'h8000, 16'hFE00};
    logic [31:0] tp_exp[8];

    initial begin
        // Reset state
        #2;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        #10 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Mode values for 0x8004, one cycle after acceptance
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            in_valid = 1'b1; in_imm = 16'h8004; in_mode = 2'(m);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("mode%0d 0x8004 valid", m), 64'(out_valid), 64'd1);
            check($sformatf("mode%0d 0x8004 data", m), 64'(out_data), 64'(exp_mode[m]));
        end

        // Positive immediate
        @(negedge clk);
        in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 2'd0;
        @(negedge clk);
        in_mode = 2'd3;
        check("sign 0x7FFF", 64'(out_data), 64'h00007FFF);
        @(negedge clk);
        in_valid = 1'b0;
        check("branch 0x7FFF", 64'(out_data), 64'h0001FFFC);
        repeat (2) @(negedge clk);

        // Backpressure: 1, 2, 3 with out_ready low
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'd1;
        @(negedge clk);
        check("bp ready after 1st", 64'(in_ready), 64'd1);
        check("bp data after 1st", 64'(out_data), 64'h1);
        in_imm = 16'h0002;
        @(negedge clk);
        check("bp ready after 2nd", 64'(in_ready), 64'd0);
        check("bp data after 2nd", 64'(out_data), 64'h1);
        in_imm = 16'h0003;
        in_mode = 2'd2;   // changes while stalled must not matter to held data
        @(negedge clk);
        check("bp stall data", 64'(out_data), 64'h1);
        in_mode = 2'd1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp drain 2", 64'(out_data), 64'h2);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp drain 3", 64'(out_data), 64'h3);
        @(negedge clk);
        check("bp empty", 64'(out_valid), 64'd0);

        // Full throughput: 8 back-to-back
        for (int i = 0; i < 10; i++) begin
            if (i >= 1 && i <= 8) begin
                check($sformatf("tp%0d valid", i - 1), 64'(out_valid), 64'd1);
                check($sformatf("tp%0d data", i - 1), 64'(out_data), 64'(tp_exp[i - 1]));
            end
            if (i < 8) begin
                check($sformatf("tp%0d in_ready", i), 64'(in_ready), 64'd1);
                in_valid = 1'b1;
                in_imm   = 16'($urandom);
                in_mode  = 2'($urandom_range(0, 3));
                tp_exp[i] = ref_ext(in_imm, in_mode);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("tp drained", 64'(out_valid), 64'd0);

        // Reset mid-operation while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'd0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        check("pre-reset full", 64'(in_ready), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst out_data", 64'(out_data), 64'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("post-reset no stale", 64'(out_valid), 64'd0);

        // Randomised traffic, checked by the compare process
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("random drained", 64'(out_valid), 64'd0);

        // Parameter sweep, IN_W=8 OUT_W=16
        out8_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            in8_valid = 1'b1; in8_imm = 8'h80; in8_mode = 2'(m);
            @(negedge clk);
            in8_valid = 1'b0;
            check($sformatf("w8 mode%0d valid", m), 64'(out8_valid), 64'd1);
            check($sformatf("w8 mode%0d data", m), 64'(out8_data), 64'(exp_mode8[m]));
            @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
